// File: rtl/reaction_fsm_pkg.sv
// Shared types and constants for the reaction timer round controller.
`timescale 1ns/1ps
package reaction_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        GO,
        DONE,
        FOUL
    } state_t;

    localparam int          CNT_W     = 14;
    // Galois form of x^16+x^14+x^13+x^11+1, right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
`timescale 1ns/1ps
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic       meta;
    logic       sync;
    logic       low_q;
    logic [1:0] ready_q;

    // ready_q marks when sync carries a genuinely sampled input rather than its
    // reset value, so an input already high at reset release never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            low_q   <= 1'b0;
            ready_q <= 2'b00;
            rise    <= 1'b0;
        end else begin
            meta    <= d;
            sync    <= meta;
            ready_q <= {ready_q[0], 1'b1};
            low_q   <= ~sync & ready_q[1];
            rise    <= sync & low_q;
        end
    end

endmodule

// File: rtl/reaction_fsm.sv
// Reaction timer round controller: random arm delay, GO light, millisecond count.
`timescale 1ns/1ps
module reaction_fsm
    import reaction_fsm_pkg::*;
#(
    parameter int          MAX_MS          = 9999,
    parameter int          DELAY_MIN_MS    = 1000,
    parameter int          DELAY_SPAN_BITS = 11,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_out,
    input  logic             start_btn,
    input  logic             react_btn,
    output logic             go_led,
    output logic [CNT_W-1:0] result_ms,
    output logic             result_valid,
    output logic             false_start,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_MS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             tick;
    logic             start_ev;
    logic             react_ev;
    logic [15:0]      lfsr;
    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] delay_cnt;
    logic [CNT_W-1:0] delay_n;
    logic [CNT_W-1:0] delay_load;
    logic [CNT_W-1:0] ms_cnt;
    logic [CNT_W-1:0] ms_n;
    logic [CNT_W-1:0] ms_inc;
    logic [CNT_W-1:0] result_n;
    logic             valid_n;
    logic             timeout_n;
    logic             saturate;

    sync_edge u_tick  (.clk(clk), .reset(reset), .d(clk_out),   .rise(tick));
    sync_edge u_start (.clk(clk), .reset(reset), .d(start_btn), .rise(start_ev));
    sync_edge u_react (.clk(clk), .reset(reset), .d(react_btn), .rise(react_ev));

    assign delay_load = CNT_W'(DELAY_MIN_MS) + CNT_W'(lfsr[DELAY_SPAN_BITS-1:0]);
    assign ms_inc     = ms_cnt + ONE;

    always_comb begin
        state_n  = state_q;
        delay_n  = delay_cnt;
        ms_n     = ms_cnt;
        result_n = result_ms;
        valid_n  = 1'b0;
        saturate = 1'b0;
        case (state_q)
            IDLE, DONE, FOUL: begin
                if (start_ev) begin
                    delay_n = delay_load;
                    state_n = ARMED;
                end
            end
            ARMED: begin
                // react wins over the final delay tick: pressing early is always a foul
                if (react_ev) begin
                    state_n = FOUL;
                end else if (tick) begin
                    delay_n = delay_cnt - ONE;
                    if (delay_cnt == ONE) begin
                        state_n = GO;
                        ms_n    = '0;
                    end
                end
            end
            GO: begin
                if (react_ev) begin
                    state_n  = DONE;
                    result_n = ms_cnt;
                    valid_n  = 1'b1;
                end else if (tick) begin
                    ms_n = ms_inc;
                    if (ms_inc == MAX_VAL) begin
                        state_n  = DONE;
                        result_n = MAX_VAL;
                        valid_n  = 1'b1;
                        saturate = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        timeout_n = (state_n == DONE) && (saturate || timeout);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr         <= LFSR_SEED;
            delay_cnt    <= '0;
            ms_cnt       <= '0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            go_led       <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_n;
            lfsr         <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & LFSR_TAPS);
            delay_cnt    <= delay_n;
            ms_cnt       <= ms_n;
            result_ms    <= result_n;
            result_valid <= valid_n;
            go_led       <= (state_n == GO);
            false_start  <= (state_n == FOUL);
            timeout      <= timeout_n;
            busy         <= (state_n == ARMED) || (state_n == GO);
        end
    end

endmodule

// File: doc/reaction_fsm.md
# reaction_fsm

Round controller for the reaction timer. It consumes the 1 kHz square wave from the clock divider, turns it into a one-cycle millisecond strobe, and sequences each round: arm on the start button, wait a pseudo-random delay, light the GO LED, then count milliseconds until the react button is pressed. It sits between the clock divider and the display driver, which reads `result_ms`.

## Interface
Parameters:
- `MAX_MS`, 9999: saturation and timeout value for the reaction count.
- `DELAY_MIN_MS`, 1000: minimum armed delay.
- `DELAY_SPAN_BITS`, 11: number of random bits added to the delay, so the delay range is DELAY_MIN_MS .. DELAY_MIN_MS+2^DELAY_SPAN_BITS-1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk`, in, 1: system clock (50 MHz).
- `reset`, in, 1: asynchronous, active-high reset.
- `clk_out`, in, 1: 1 kHz square wave from the clock divider. It is asynchronous to `clk` and synchronised internally.
- `start_btn`, in, 1: raw, active-high start button.
- `react_btn`, in, 1: raw, active-high react button.
- `go_led`, out, 1: high while in GO.
- `result_ms`, out, 14: last reaction time in ms.
- `result_valid`, out, 1: one-cycle pulse when `result_ms` updates.
- `false_start`, out, 1: high while in FOUL.
- `timeout`, out, 1: high in DONE when the round ended by saturation.
- `busy`, out, 1: high in ARMED or GO.

## Operation
Each of the three inputs passes through a 2-flop synchroniser and a rising-edge detector, producing `tick`, `start_ev` and `react_ev`. Levels are not acted on; only rising edges are events.

The LFSR is a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1. It advances every `clk` cycle, so the random value depends on when the user presses start.

States are IDLE, ARMED, GO, DONE and FOUL:
- **IDLE:** on `start_ev`, load `delay_cnt = DELAY_MIN_MS + lfsr[DELAY_SPAN_BITS-1:0]`, go to ARMED.
- **ARMED:**
  - `react_ev` → FOUL.
  - Otherwise, on `tick`, decrement `delay_cnt`. When the value before the decrement is 1, go to GO with `ms_cnt = 0`.
- **GO:**
  - `react_ev` → DONE, with `result_ms = ms_cnt` and `result_valid` pulsed.
  - Otherwise, on `tick`, increment `ms_cnt`. If the new value equals MAX_MS → DONE, with `result_ms = MAX_MS`, `timeout = 1` and `result_valid` pulsed.
- **DONE / FOUL:** on `start_ev`, reload the delay as in IDLE and go to ARMED. Clear `timeout` and `false_start` on leaving.
- `start_ev` in ARMED or GO is ignored.

Priority rules:
- `react_ev` beats `tick` in the same cycle.
  - In ARMED this gives FOUL, even when the delay would expire that cycle.
  - In GO the captured value is the pre-increment `ms_cnt`.
- `react_ev` in IDLE, DONE or FOUL is ignored.

Arithmetic:
- `ms_cnt` and `result_ms` are 14 bits unsigned.
- `delay_cnt` is 14 bits wide and never wraps; it is loaded only with values of at least 1.

## Timing
- Reset values:
  - state IDLE.
  - `go_led`, `result_valid`, `false_start`, `timeout`, `busy` all 0.
  - `result_ms` 0.
  - LFSR at LFSR_SEED; counters 0.
  - Synchroniser and edge flops 0, so an input that is high during reset produces no event.
- Input-to-event latency: an input sampled high at `clk` edge k gives an event pulse valid in the cycle after edge k+2 (3-cycle latency).
- Outputs are registered.
  - `go_led` rises on the same edge as the state change to GO.
  - `result_ms` and `result_valid` update on the edge that leaves GO.
- `result_ms` holds its value until the next `result_valid`. A FOUL does not clear it.
- Reset asserted mid-round returns the block to IDLE immediately, and `go_led` drops asynchronously.

## Structure
- A shared package holds:
  - the state enum: IDLE, ARMED, GO, DONE, FOUL.
  - the counter width constant: 14.
  - the LFSR tap mask: 16'hB400.
- One sub-module, `sync_edge`: 2-flop synchroniser plus rising-edge pulse, ports `clk`, `reset`, `d`, `rise`. It is instantiated three times.
- The LFSR, counters and FSM stay inline.

## Test plan
For speed, the bench drives `clk_out` with a 20-cycle period and sets DELAY_MIN_MS=4, DELAY_SPAN_BITS=2.
1. **Reset:** hold `start_btn` high through reset release → no transition out of IDLE, all outputs 0, `result_ms`=0.
2. **Normal round:** start pulse, wait for `go_led`, press react after 7 `clk_out` rising edges → `result_valid` pulses once, `result_ms`=7, `go_led`=0, `timeout`=0.
3. **False start:** press react while in ARMED → `false_start`=1, `go_led` never rises, `result_ms` unchanged. A later start → ARMED with `false_start`=0.
4. **Timeout:** MAX_MS=12, no react → DONE after 12 ticks, `result_ms`=12, `timeout`=1, single `result_valid`.
5. **Simultaneous events:**
   - react edge coincident with the final delay tick → FOUL.
   - react edge coincident with a tick in GO at `ms_cnt`=5 → `result_ms`=5.
6. **Reset mid-round:** assert reset in GO at `ms_cnt`=3 → `go_led` drops without waiting for a clock edge, state IDLE, `result_ms`=0. The delay loaded for the next round lies within [4,7] ms.
